// File: rtl/delay_pipeline_ctrl.sv
// Valid/ready flow control wrapped around a fixed-latency delay line.
// Tracks stage validity, stalls only on output backpressure, supports flush.
module delay_pipeline_ctrl #(
    parameter int CYCLES = 4,
    localparam int OW = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          flush,
    output logic          en,
    output logic [OW-1:0] occupancy,
    output logic          empty
);

    if (CYCLES == 0) begin : g_pass
        assign out_valid = in_valid && !flush;
        assign in_ready  = out_ready && !flush && rst;
        assign en        = 1'b1;
        assign occupancy = '0;
        assign empty     = 1'b1;
    end else begin : g_pipe
        logic [CYCLES-1:0] valid_q, valid_d;
        logic [OW-1:0]     occ_q, occ_d;
        logic              accept, emit;

        assign out_valid = valid_q[CYCLES-1] && !flush;
        assign en        = !(out_valid && !out_ready);
        assign in_ready  = en && !flush && rst;
        assign accept    = in_valid && in_ready;
        assign emit      = out_valid && out_ready;

        // Stalls freeze every stage so bubbles keep their slots.
        always_comb begin
            valid_d = valid_q;
            occ_d   = occ_q;
            if (en) begin
                for (int i = CYCLES - 1; i > 0; i--) begin
                    valid_d[i] = valid_q[i-1];
                end
                valid_d[0] = accept;
                occ_d      = occ_q + OW'(accept) - OW'(emit);
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_q <= '0;
                occ_q   <= '0;
            end else if (flush) begin
                valid_q <= '0;
                occ_q   <= '0;
            end else begin
                valid_q <= valid_d;
                occ_q   <= occ_d;
            end
        end

        assign occupancy = occ_q;
        assign empty     = (occ_q == '0);
    end

endmodule

// File: tb/tb_delay_pipeline_ctrl.sv
// Directed bench for delay_pipeline_ctrl driving an 8-bit, 4-stage delay line.
module tb_delay_pipeline_ctrl;

    localparam int CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, flush, en, empty;
    logic [2:0] occupancy;
    logic [7:0] din;
    logic [7:0] dly [CYCLES];
    logic [7:0] dout;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       iv, ordy, fl;
        logic [7:0] din;
        logic       ov, ir, en;
        logic [2:0] occ;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl[$];

    delay_pipeline_ctrl #(.CYCLES(CYCLES)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .flush(flush), .en(en),
        .occupancy(occupancy), .empty(empty)
    );

    always #5 clk = ~clk;

    // Reference delay line controlled by the DUT enable.
    always_ff @(posedge clk) begin
        if (en) begin
            dly[0] <= din;
            for (int i = 1; i < CYCLES; i++) dly[i] <= dly[i-1];
        end
    end
    assign dout = dly[CYCLES-1];

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic iv, ordy, fl, input logic [7:0] d,
                       input logic ov, ir, e, input logic [2:0] oc,
                       input logic [7:0] dq);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.din = d;
        v.ov = ov; v.ir = ir; v.en = e; v.occ = oc; v.dout = dq;
        tbl.push_back(v);
    endtask

    initial begin
        int hits;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        flush = 1'b0; din = 8'h00;

        // streaming, then drain
        add(1,1,0,8'h01, 0,1,1,0,8'h00);
        add(1,1,0,8'h02, 0,1,1,1,8'h00);
        add(1,1,0,8'h03, 0,1,1,2,8'h00);
        add(1,1,0,8'h04, 0,1,1,3,8'h00);
        add(1,1,0,8'h05, 1,1,1,4,8'h01);
        add(1,1,0,8'h06, 1,1,1,4,8'h02);
        add(0,1,0,8'h00, 1,1,1,4,8'h03);
        add(0,1,0,8'h00, 1,1,1,3,8'h04);
        add(0,1,0,8'h00, 1,1,1,2,8'h05);
        add(0,1,0,8'h00, 1,1,1,1,8'h06);
        add(0,1,0,8'h00, 0,1,1,0,8'h00);
        // backpressure
        add(1,1,0,8'hA0, 0,1,1,0,8'h00);
        add(1,1,0,8'hA1, 0,1,1,1,8'h00);
        add(1,1,0,8'hA2, 0,1,1,2,8'h00);
        add(1,1,0,8'hA3, 0,1,1,3,8'h00);
        for (int i = 0; i < 5; i++) add(1,0,0,8'hFF, 1,0,0,4,8'hA0);
        add(0,1,0,8'h00, 1,1,1,4,8'hA0);
        add(0,1,0,8'h00, 1,1,1,3,8'hA1);
        add(0,1,0,8'h00, 1,1,1,2,8'hA2);
        add(0,1,0,8'h00, 1,1,1,1,8'hA3);
        add(0,1,0,8'h00, 0,1,1,0,8'h00);
        // bubbles
        add(1,1,0,8'h11, 0,1,1,0,8'h00);
        add(0,1,0,8'h00, 0,1,1,1,8'h00);
        add(1,1,0,8'h22, 0,1,1,1,8'h00);
        add(0,1,0,8'h00, 0,1,1,2,8'h00);
        add(0,1,0,8'h00, 1,1,1,2,8'h11);
        add(0,1,0,8'h00, 0,1,1,1,8'h00);
        add(0,1,0,8'h00, 1,1,1,1,8'h22);
        add(0,1,0,8'h00, 0,1,1,0,8'h00);
        // flush with 3 in flight and in_valid high
        add(1,1,0,8'h31, 0,1,1,0,8'h00);
        add(1,1,0,8'h32, 0,1,1,1,8'h00);
        add(1,1,0,8'h33, 0,1,1,2,8'h00);
        add(1,1,1,8'h34, 0,0,1,3,8'h00);
        for (int i = 0; i < 5; i++) add(0,1,0,8'h00, 0,1,1,0,8'h00);
        // flush while the output is stalled
        add(1,1,0,8'h41, 0,1,1,0,8'h00);
        add(1,1,0,8'h42, 0,1,1,1,8'h00);
        add(1,1,0,8'h43, 0,1,1,2,8'h00);
        add(1,1,0,8'h44, 0,1,1,3,8'h00);
        add(0,0,1,8'h00, 0,0,1,4,8'h00);
        add(0,0,0,8'h00, 0,1,1,0,8'h00);

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", 0, 32'(in_ready), 0);
        chk("rst_en", 0, 32'(en), 1);
        chk("rst_out_valid", 0, 32'(out_valid), 0);
        chk("rst_occ", 0, 32'(occupancy), 0);
        chk("rst_empty", 0, 32'(empty), 1);
        rst = 1'b1;

        foreach (tbl[k]) begin
            @(negedge clk);
            in_valid = tbl[k].iv; out_ready = tbl[k].ordy;
            flush = tbl[k].fl; din = tbl[k].din;
            #1;
            chk("out_valid", k, 32'(out_valid), 32'(tbl[k].ov));
            chk("in_ready", k, 32'(in_ready), 32'(tbl[k].ir));
            chk("en", k, 32'(en), 32'(tbl[k].en));
            chk("occ", k, 32'(occupancy), 32'(tbl[k].occ));
            chk("empty", k, 32'(empty), 32'(tbl[k].occ == 3'd0));
            if (tbl[k].ov) chk("dout", k, 32'(dout), 32'(tbl[k].dout));
        end

        // mid-stream asynchronous reset
        @(negedge clk); in_valid = 1; out_ready = 1; flush = 0; din = 8'h61;
        @(negedge clk); din = 8'h62;
        @(negedge clk); in_valid = 0; din = 8'h00;
        @(negedge clk);
        @(negedge clk); out_ready = 0;
        #1;
        chk("pre_rst_ov", 0, 32'(out_valid), 1);
        chk("pre_rst_occ", 0, 32'(occupancy), 2);
        chk("pre_rst_en", 0, 32'(en), 0);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_ov", 0, 32'(out_valid), 0);
        chk("mid_rst_occ", 0, 32'(occupancy), 0);
        chk("mid_rst_ir", 0, 32'(in_ready), 0);
        chk("mid_rst_en", 0, 32'(en), 1);
        chk("mid_rst_empty", 0, 32'(empty), 1);
        @(negedge clk); rst = 1'b1; out_ready = 1;
        #1;
        chk("post_rst_ir", 0, 32'(in_ready), 1);
        @(negedge clk); in_valid = 1; din = 8'h5A;
        #1;
        chk("acc_5a_ir", 0, 32'(in_ready), 1);
        chk("acc_5a_ov", 0, 32'(out_valid), 0);
        hits = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk); in_valid = 0; din = 8'h00;
            #1;
            chk("lat_ov", j, 32'(out_valid), 32'(j == 3));
            if (out_valid) begin
                hits++;
                chk("lat_dout", j, 32'(dout), 32'h5A);
            end
        end
        chk("lat_hits", 0, 32'(hits), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/delay_pipeline_ctrl.md
# delay_pipeline_ctrl

Flow controller for the `delay` datapath block. It converts the delay's bare enable into a valid/ready streaming pipeline. It tracks which delay stages hold valid data and stalls the whole pipe only when the output holds valid data that downstream is not accepting. Upstream and downstream see a standard valid/ready interface, and the delay instance is driven from this block's `en` output.

## Interface
- `CYCLES`, default 4: stage count of the controlled `delay` instance; must equal that instance's `CYCLES`; ≥ 0.
- `clk`  in  1  clock shared with the controlled `delay`.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream has a word on the delay's `in`.
- `in_ready`  out  1  word on `in` is captured this cycle if `in_valid`.
- `out_valid`  out  1  delay's `out` holds a valid word.
- `out_ready`  in  1  downstream accepts `out` this cycle.
- `flush`  in  1  synchronous discard of all in-flight words.
- `en`  out  1  enable to the `delay` instance.
- `occupancy`  out  $clog2(CYCLES+1)  number of valid words currently in the pipe.
- `empty`  out  1  `occupancy == 0`.

## Operation
- Internal `valid_r[CYCLES-1:0]` mirrors the delay stages. Bit `i` is set when stage `i` holds a valid word. `out_valid = valid_r[CYCLES-1]` (flush gating below).
- Stall rule: `en = !(out_valid && !out_ready)`. A stall freezes all stages, so bubbles are never collapsed.
- `in_ready = en && !flush && rst`, combinational. `in_ready` is 0 throughout reset.
- On posedge with `en` high:
  - `valid_r[0] <= in_valid && in_ready`
  - `valid_r[i] <= valid_r[i-1]`
  - The delay advances and captures `in` whether or not `in_valid` is set; invalid captures are bubbles.
- On posedge with `en` low: `valid_r` holds.
- `accept = in_valid && in_ready` and `emit = out_valid && out_ready`. `occupancy` updates as `+accept − emit`; both together leave it unchanged. `occupancy` never exceeds `CYCLES`.
- Flush has priority over everything:
  - During the `flush` cycle, `out_valid` is forced 0 (no emit), `in_ready` is 0 (no accept), and `en` is 1.
  - At that posedge, `valid_r` and `occupancy` clear to 0.
  - Stale data left in the delay stages is irrelevant because its valid bits are cleared.
- `CYCLES == 0`: no state. `out_valid = in_valid && !flush`, `in_ready = out_ready && !flush && rst`, `en = 1`, `occupancy = 0`, `empty = 1`.
- Reset: `valid_r = 0`, `occupancy = 0`, `out_valid = 0`, `empty = 1`, `in_ready = 0`, `en = 1` (the delay is held by its own reset). Reset applied mid-stream discards all in-flight words immediately and asynchronously.

## Timing
- Latency: a word accepted at edge k is presented at the output (`out_valid = 1`) after CYCLES − 1 further edges with `en = 1`. With no stalls, `out_valid` rises CYCLES − 1 cycles after acceptance, aligned with the delay `out` for `CYCLES ≥ 1`.
- Throughput is 1 word/cycle when `out_ready` is held high.
- `en`, `in_ready` and `out_valid` are combinational from `out_ready`, `flush`, `rst` and registered state. No other combinational input→output paths exist.
- `in_valid` does not affect `en` or `in_ready`, so there is no ready-depends-on-valid loop.
- `occupancy` and `empty` are registered-derived and reflect state after the last edge.
- First edge after `rst` rises: inputs may be accepted.

## Test plan
All scenarios use `CYCLES = 4` and the controller connected to a real `delay` with `WIDTH = 8`.

- Streaming: `in_valid = 1`, `out_ready = 1`, `in` = 0x01, 0x02, … → `out_valid` first high 3 cycles after first accept, outputs 0x01, 0x02, … in order, `occupancy` settles at 4, no stalls.
- Backpressure: fill 4 words 0xA0–0xA3, then `out_ready = 0` for 5 cycles → `en = 0`, `in_ready = 0`, `out` holds 0xA0 stable, `occupancy = 4`. Releasing `out_ready` yields 0xA0–0xA3 with no loss or duplication.
- Bubbles: `in_valid` pattern 1,0,1,0 with values 0x11, 0x22 → `out_valid` pattern 1,0,1,0 with 0x11, 0x22. `occupancy` peaks at 2.
- Simultaneous accept/emit at full: `occupancy = 4`, `in_valid = 1`, `out_ready = 1` → `occupancy` stays 4 and `empty` stays 0.
- Flush: 3 words in flight plus `flush` pulse, with `in_valid = 1` during the pulse → no emit and no accept that cycle. Next cycle `occupancy = 0` and `empty = 1`, and no flushed word ever appears with `out_valid = 1`.
- Reset mid-operation: assert `rst = 0` between edges with 2 words in flight → `out_valid`, `occupancy` and `in_ready` go to 0 immediately. After release, a new word 0x5A emerges alone after the nominal latency.
